vgm_ahb_mem_slave: RTL and testbench
====================================

Name: vgm_ahb_mem_slave

Overview:
- Parametrised AHB-Lite memory slave: single-port word-organised memory behind a standard AHB-Lite slave interface.
- Adds configurable data width, depth, base address, separate NONSEQ/SEQ wait states, byte-lane writes and two-cycle ERROR responses.
- Used as the DUT and reference target for the team's AHB sequences and protocol properties.

Parameters:
- ADDR_WIDTH, 32, width of HADDR.
- DATA_WIDTH, 32, width of HWDATA/HRDATA; legal values are 32 or 64.
- DEPTH, 1024, number of DATA_WIDTH-bit words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DEPTH*DATA_WIDTH/8.
- NSEQ_WAIT, 2, wait states inserted for a NONSEQ data phase (0..15).
- SEQ_WAIT, 0, wait states inserted for a SEQ data phase (0..15).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of bytes.
- HBURST  in  3  burst type: SINGLE, INCR, WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus ready (mux output).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Reset asserted mid-transfer aborts the transfer with no memory write; outputs take reset values on the next edge.
- Address phase is accepted on an edge where HSEL & HREADY & HTRANS[1]. Address, size, write and trans are registered.
- IDLE or BUSY accepted while selected: next data phase is zero-wait OKAY with no side effect.
- Error check at acceptance. Any of the following gives ERROR:
  - HADDR outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8).
  - HSIZE > log2(DATA_WIDTH/8).
  - HADDR not aligned to 2^HSIZE.
- FSM states and transitions:
  - IDLE: waits for an accepted transfer. Goes to WAIT if the wait count > 0, ERR1 on error, otherwise DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter counts down from NSEQ_WAIT or SEQ_WAIT (chosen by the registered HTRANS); at 1, goes to DATA.
  - DATA: HREADYOUT=1, HRESP=0. Transfer completes in this cycle. On the same edge, a newly accepted transfer selects the next state (WAIT, ERR1 or DATA); otherwise the FSM returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; the next transfer is accepted as in DATA. An errored transfer never writes memory.
- Latency: total data phase = wait count + 1 cycles (NSEQ_WAIT+1 or SEQ_WAIT+1).
- Writes:
  - Committed on the completing DATA edge using HWDATA sampled on that edge.
  - Byte enables come from HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0], little-endian.
  - Unselected bytes are unchanged.
- Reads:
  - HRDATA carries the full word in every cycle where HREADYOUT=1 in DATA; the bus master selects lanes.
  - HRDATA holds its last value in all other cycles.
- Back-to-back read of the address written by the immediately preceding transfer returns the newly written data (forwarding required when NSEQ_WAIT=0).
- Word index = (HADDR - BASE_ADDR) >> log2(DATA_WIDTH/8); no wrap-around; out-of-range addresses always error.

Optional Feature:
- Macro VGM_AHB_MEM_SLAVE_BURST_CHECK_EN.
- Defined: the slave tracks the expected next burst address.
  - INCR types: previous address + 2^HSIZE.
  - WRAP4/8/16: increment within a boundary of beats*2^HSIZE bytes, wrapping to the boundary start.
  - A SEQ whose HADDR or HSIZE differs from the expected value returns ERROR.
  - A SEQ without a preceding NONSEQ/SEQ in the same burst returns ERROR.
  - Tracking state is cleared by reset and by IDLE.
- Undefined: SEQ is checked only by the generic error rules; HBURST is ignored.

Test Plan:
- Reset, then single NONSEQ word write 0xDEADBEEF to BASE_ADDR+0x10, then read -> write takes 3 cycles with HREADYOUT low 2 cycles; read returns 0xDEADBEEF, HRESP=0.
- Byte write 0xAA, HSIZE=0, to BASE_ADDR+0x11 over word 0x00000000 -> read word returns 0x0000AA00.
- INCR4 word read from BASE_ADDR+0x0 with SEQ_WAIT=0 -> beat 1 takes 3 cycles, beats 2-4 take 1 cycle each, data matches preloaded words 0..3.
- Read at BASE_ADDR + DEPTH*4 (out of range) -> ERR1 then ERR2: HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged.
- HSIZE=1 write to odd address BASE_ADDR+0x3 -> two-cycle ERROR, no write. HSIZE=3 with DATA_WIDTH=32 -> ERROR.
- Burst check enabled: WRAP4 word burst starting at 0x08 with addresses 0x08, 0x0C, 0x00, 0x04 -> all OKAY. Same burst with third beat 0x10 -> third beat ERROR.

Source files
------------

// File: rtl/vgm_ahb_mem_slave.sv
// vgm_ahb_mem_slave: AHB-Lite single-port memory slave.
// Word-organised memory with byte-lane writes, separate NONSEQ/SEQ wait
// states and two-cycle ERROR responses.
// Optional: define VGM_AHB_MEM_SLAVE_BURST_CHECK_EN to check that every SEQ
// beat follows the burst address sequence of the preceding beat.
module vgm_ahb_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NSEQ_WAIT  = 2,
    parameter int                    SEQ_WAIT   = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    LSB       = $clog2(BYTES);
    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * BYTES);
    localparam logic [3:0]            NW        = 4'(NSEQ_WAIT);
    localparam logic [3:0]            SW        = 4'(SEQ_WAIT);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic                  ready_reg;
    logic                  resp_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [BYTES-1:0]      be_reg;
    logic                  write_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
    logic [BYTES-1:0]      fwd_be_reg;
    logic                  fwd_reg;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  burst_err;
    logic [7:0]            align_mask;
    logic [IDX_W-1:0]      acc_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [BYTES-1:0]      be_base;
    logic [BYTES-1:0]      be_acc;
    logic                  can_accept;
    logic                  accept;
    logic                  idle_acc;
    logic                  acc_err;
    logic [3:0]            acc_wait;
    logic                  acc_to_data;
    logic                  do_write;
    logic                  wait_done;
    logic                  load_rd;

    // Address-phase decode: range/size/alignment errors, word index and byte lanes
    always_comb begin
        offset      = HADDR - BASE_ADDR;
        range_err   = (HADDR < BASE_ADDR) || (offset >= MEM_BYTES);
        size_err    = HSIZE > 3'(LSB);
        align_mask  = (8'd1 << HSIZE) - 8'd1;
        align_err   = |(HADDR[7:0] & align_mask);
        acc_idx     = offset[LSB +: IDX_W];
        be_base     = '0;
        for (int b = 0; b < BYTES; b++) begin
            be_base[b] = 32'(b) < (32'd1 << HSIZE);
        end
        be_acc      = be_base << HADDR[LSB-1:0];
        can_accept  = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
        accept      = HSEL && HREADY && HTRANS[1] && can_accept;
        idle_acc    = HSEL && HREADY && (HTRANS == 2'b00) && can_accept;
        acc_err     = range_err || size_err || align_err || burst_err;
        acc_wait    = HTRANS[0] ? SW : NW;
        acc_to_data = accept && !acc_err && (acc_wait == 4'd0);
        do_write    = (state_reg == ST_DATA) && write_reg;
        wait_done   = (state_reg == ST_WAIT) && (cnt_reg <= 4'd1);
        load_rd     = acc_to_data || wait_done;
        rd_idx      = (state_reg == ST_WAIT) ? idx_reg : acc_idx;
    end

`ifdef VGM_AHB_MEM_SLAVE_BURST_CHECK_EN
    logic                  bvalid_reg;
    logic [ADDR_WIDTH-1:0] bnext_reg;
    logic [2:0]            bsize_reg;
    logic [ADDR_WIDTH-1:0] binc;
    logic [ADDR_WIDTH-1:0] bbound;
    logic [ADDR_WIDTH-1:0] bnext_calc;

    // Next expected burst address; WRAP types wrap inside beats*size bytes
    always_comb begin
        binc = ADDR_WIDTH'(1) << HSIZE;
        case (HBURST)
            3'd2:    bbound = binc << 2;
            3'd4:    bbound = binc << 3;
            3'd6:    bbound = binc << 4;
            default: bbound = '0;
        endcase
        if (bbound == '0) begin
            bnext_calc = HADDR + binc;
        end else begin
            bnext_calc = (HADDR & ~(bbound - 1'b1)) | ((HADDR + binc) & (bbound - 1'b1));
        end
        burst_err = (HTRANS == 2'b11) &&
                    (!bvalid_reg || (HADDR != bnext_reg) || (HSIZE != bsize_reg));
    end

    // Burst tracker: armed by a good NONSEQ/SEQ, dropped by errors and IDLE
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bvalid_reg <= 1'b0;
            bnext_reg  <= '0;
            bsize_reg  <= '0;
        end else if (accept) begin
            bvalid_reg <= !acc_err;
            bnext_reg  <= bnext_calc;
            bsize_reg  <= HSIZE;
        end else if (idle_acc) begin
            bvalid_reg <= 1'b0;
        end
    end
`else
    logic unused_burst;
    assign burst_err    = 1'b0;
    assign unused_burst = ^HBURST;
`endif

    // Transfer FSM with registered HREADYOUT/HRESP
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            resp_reg  <= 1'b0;
            idx_reg   <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        idx_reg   <= acc_idx;
                        be_reg    <= be_acc;
                        write_reg <= HWRITE && !acc_err;
                        cnt_reg   <= acc_wait;
                        if (acc_err) begin
                            state_reg <= ST_ERR1;
                            ready_reg <= 1'b0;
                            resp_reg  <= 1'b1;
                        end else if (acc_wait != 4'd0) begin
                            state_reg <= ST_WAIT;
                            ready_reg <= 1'b0;
                            resp_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_DATA;
                            ready_reg <= 1'b1;
                            resp_reg  <= 1'b0;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                        write_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        resp_reg  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= ST_DATA;
                        ready_reg <= 1'b1;
                        resp_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_reg <= ST_ERR2;
                    ready_reg <= 1'b1;
                    resp_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    resp_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write committed on the completing DATA edge; reset aborts it
    always_ff @(posedge HCLK) begin
        if (!HRESET && do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_reg[b]) begin
                    mem[idx_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    // Registered read on entry to DATA, capturing a same-edge write for bypass
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rdata_reg    <= '0;
            fwd_reg      <= 1'b0;
            fwd_data_reg <= '0;
            fwd_be_reg   <= '0;
        end else if (load_rd) begin
            rdata_reg    <= mem[rd_idx];
            fwd_reg      <= do_write && acc_to_data && (idx_reg == acc_idx);
            fwd_data_reg <= HWDATA;
            fwd_be_reg   <= be_reg;
        end
    end

    // Merge forwarded write bytes over the stale memory word
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_rd_lane
            assign HRDATA[gi*8 +: 8] = (fwd_reg && fwd_be_reg[gi]) ?
                                       fwd_data_reg[gi*8 +: 8] : rdata_reg[gi*8 +: 8];
        end
    endgenerate

    assign HREADYOUT = ready_reg;
    assign HRESP     = resp_reg;

endmodule

// File: tb/tb_vgm_ahb_mem_slave.sv
// Testbench for vgm_ahb_mem_slave: pipelined AHB-Lite master driving beat
// lists, checked against a byte-level memory model and the transfer rules.
module tb_vgm_ahb_mem_slave;

    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          NW    = 2;
    localparam int          SW    = 0;
    localparam int          MEMB  = DEPTH * 4;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    int errors = 0;
    int checks = 0;

    // beat list and per-beat results / expectations
    int          nb;
    logic [31:0] b_addr  [16];
    logic        b_wr    [16];
    logic [2:0]  b_size  [16];
    logic [1:0]  b_trans [16];
    logic [2:0]  b_burst [16];
    logic [31:0] b_wdata [16];
    int          r_cycles[16];
    logic        r_resp0 [16];
    logic        r_resp  [16];
    logic [31:0] r_rdata [16];
    int          e_cycles[16];
    logic        e_err   [16];
    logic [31:0] e_rdata [16];

    logic [7:0]  mm [MEMB];

    vgm_ahb_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .NSEQ_WAIT(NW), .SEQ_WAIT(SW)
    ) dut (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
    );

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [2:0] burst);
        int unsigned inc, beats, bnd, base;
        inc   = 1 << s;
        beats = (burst == 3'd2) ? 4 : (burst == 3'd4) ? 8 : (burst == 3'd6) ? 16 : 0;
        if (beats == 0) return a + inc;
        bnd  = beats * inc;
        base = a - (a % bnd);
        return base + ((a - base + inc) % bnd);
    endfunction

    // Transaction-level reference: error rules, latency, byte-lane memory
    task automatic model_expect();
        logic        have_prev = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [2:0]  prev_size = '0;
        for (int i = 0; i < nb; i++) begin
            longint off;
            logic   err;
            int     w;
            off = longint'(b_addr[i]) - longint'(BASE);
            err = (off < 0) || (off >= MEMB) || (b_size[i] > 3'd2) ||
                  ((b_addr[i] % (32'd1 << b_size[i])) != 0);
`ifdef VGM_AHB_MEM_SLAVE_BURST_CHECK_EN
            if (b_trans[i] == 2'b11 &&
                (!have_prev || b_addr[i] != next_addr(prev_addr, prev_size, b_burst[i]) ||
                 b_size[i] != prev_size))
                err = 1'b1;
`endif
            e_err[i]    = err;
            e_cycles[i] = err ? 2 : ((b_trans[i] == 2'b11) ? SW : NW) + 1;
            e_rdata[i]  = '0;
            if (!err) begin
                w = int'(off) & ~3;
                if (!b_wr[i]) begin
                    e_rdata[i] = {mm[w+3], mm[w+2], mm[w+1], mm[w]};
                end else begin
                    for (int k = 0; k < (1 << b_size[i]); k++)
                        mm[int'(off) + k] = b_wdata[i][8*((int'(off) + k) % 4) +: 8];
                end
            end
            have_prev = !err;
            prev_addr = b_addr[i];
            prev_size = b_size[i];
        end
    endtask

    task automatic add_beat(input logic [31:0] a, input logic wr, input logic [2:0] s,
                            input logic [1:0] t, input logic [2:0] burst, input logic [31:0] d);
        b_addr[nb] = a; b_wr[nb] = wr; b_size[nb] = s;
        b_trans[nb] = t; b_burst[nb] = burst; b_wdata[nb] = d;
        nb++;
    endtask

    task automatic drive_beat(input int i);
        hsel = 1'b1; haddr = b_addr[i]; hwrite = b_wr[i];
        hsize = b_size[i]; htrans = b_trans[i]; hburst = b_burst[i];
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = '0; hburst = '0;
    endtask

    // Pipelined master: address phase of beat i+1 overlaps data phase of beat i
    task automatic run_beats();
        drive_beat(0);
        @(posedge hclk); #1;
        for (int i = 0; i < nb; i++) begin
            int cyc;
            hwdata = b_wdata[i];
            if (i + 1 < nb) drive_beat(i + 1);
            else drive_idle();
            cyc = 1;
            r_resp0[i] = hresp;
            while (!hreadyout && cyc < 40) begin
                @(posedge hclk); #1;
                cyc++;
            end
            if (!hreadyout) begin
                errors++; checks++;
                $display("FAIL timeout beat%0d addr=%h hreadyout=%b required 1", i, b_addr[i], hreadyout);
            end
            r_cycles[i] = cyc; r_resp[i] = hresp; r_rdata[i] = hrdata;
            $display("beat %0d addr=%h wr=%0d size=%0d trans=%0d cycles=%0d resp=%0d rdata=%h",
                     i, b_addr[i], b_wr[i], b_size[i], b_trans[i], cyc, hresp, hrdata);
            @(posedge hclk); #1;
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        drive_idle(); hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", hrdata); end
        hreset = 1'b0;
        @(posedge hclk); #1;
    endtask

    task automatic init_memory();
        for (int w = 0; w < DEPTH; w++) begin
            nb = 0;
            add_beat(BASE + 32'(w*4), 1'b1, 3'd2, 2'b10, 3'd0, $urandom);
            model_expect();
            run_beats();
        end
    endtask

    task automatic test_single_write_read();
        nb = 0;
        add_beat(BASE + 32'h10, 1'b1, 3'd2, 2'b10, 3'd0, 32'hDEADBEEF);
        model_expect(); run_beats();
        checks++; if (r_cycles[0] !== 3) begin errors++; $display("FAIL single_wr_cycles got=%0d exp=3", r_cycles[0]); end
        checks++; if (r_resp[0] !== 1'b0) begin errors++; $display("FAIL single_wr_resp got=%b exp=0", r_resp[0]); end
        nb = 0;
        add_beat(BASE + 32'h10, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        model_expect(); run_beats();
        checks++; if (r_cycles[0] !== 3) begin errors++; $display("FAIL single_rd_cycles got=%0d exp=3", r_cycles[0]); end
        checks++; if (r_resp[0] !== 1'b0) begin errors++; $display("FAIL single_rd_resp got=%b exp=0", r_resp[0]); end
        checks++; if (r_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data got=%h exp=deadbeef", r_rdata[0]); end
    endtask

    task automatic test_byte_write();
        nb = 0;
        add_beat(BASE + 32'h10, 1'b1, 3'd2, 2'b10, 3'd0, 32'h0);
        add_beat(BASE + 32'h11, 1'b1, 3'd0, 2'b10, 3'd0, 32'h5555AA55);
        add_beat(BASE + 32'h10, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        add_beat(BASE + 32'h16, 1'b1, 3'd1, 2'b10, 3'd0, 32'h1234ABCD);
        add_beat(BASE + 32'h14, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        model_expect(); run_beats();
        checks++; if (r_rdata[2] !== 32'h0000AA00) begin errors++; $display("FAIL byte_wr_data got=%h exp=0000aa00", r_rdata[2]); end
        for (int i = 0; i < nb; i++) begin
            checks++; if (r_resp[i] !== e_err[i]) begin errors++; $display("FAIL byte_resp beat%0d got=%b exp=%b", i, r_resp[i], e_err[i]); end
            if (!b_wr[i]) begin
                checks++; if (r_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL byte_rdata beat%0d got=%h exp=%h", i, r_rdata[i], e_rdata[i]); end
            end
        end
    endtask

    task automatic test_incr4_read();
        nb = 0;
        for (int i = 0; i < 4; i++)
            add_beat(BASE + 32'(i*4), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'd3, 32'h0);
        model_expect(); run_beats();
        for (int i = 0; i < nb; i++) begin
            checks++; if (r_cycles[i] !== ((i == 0) ? 3 : 1)) begin errors++; $display("FAIL incr4_cycles beat%0d got=%0d exp=%0d", i, r_cycles[i], (i == 0) ? 3 : 1); end
            checks++; if (r_resp[i] !== 1'b0) begin errors++; $display("FAIL incr4_resp beat%0d got=%b exp=0", i, r_resp[i]); end
            checks++; if (r_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL incr4_rdata beat%0d got=%h exp=%h", i, r_rdata[i], e_rdata[i]); end
        end
    endtask

    task automatic test_out_of_range();
        nb = 0;
        add_beat(BASE + 32'(MEMB), 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        add_beat(BASE + 32'(MEMB), 1'b1, 3'd2, 2'b10, 3'd0, 32'hBADC0DE0);
        add_beat(BASE - 32'd4,     1'b1, 3'd2, 2'b10, 3'd0, 32'hBADC0DE1);
        add_beat(BASE,             1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        model_expect(); run_beats();
        for (int i = 0; i < 3; i++) begin
            checks++; if (r_cycles[i] !== 2) begin errors++; $display("FAIL oor_cycles beat%0d got=%0d exp=2", i, r_cycles[i]); end
            checks++; if (r_resp0[i] !== 1'b1) begin errors++; $display("FAIL oor_err1_resp beat%0d got=%b exp=1", i, r_resp0[i]); end
            checks++; if (r_resp[i] !== 1'b1) begin errors++; $display("FAIL oor_err2_resp beat%0d got=%b exp=1", i, r_resp[i]); end
        end
        checks++; if (r_rdata[3] !== e_rdata[3]) begin errors++; $display("FAIL oor_mem_unchanged got=%h exp=%h", r_rdata[3], e_rdata[3]); end
    endtask

    task automatic test_misaligned();
        nb = 0;
        add_beat(BASE + 32'h3, 1'b1, 3'd1, 2'b10, 3'd0, 32'hFFFFFFFF);
        add_beat(BASE + 32'h8, 1'b0, 3'd3, 2'b10, 3'd0, 32'h0);
        add_beat(BASE + 32'h2, 1'b1, 3'd2, 2'b10, 3'd0, 32'hFFFFFFFF);
        add_beat(BASE,         1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        model_expect(); run_beats();
        for (int i = 0; i < nb; i++) begin
            checks++; if (r_resp[i] !== e_err[i]) begin errors++; $display("FAIL misalign_resp beat%0d got=%b exp=%b", i, r_resp[i], e_err[i]); end
            checks++; if (r_cycles[i] !== e_cycles[i]) begin errors++; $display("FAIL misalign_cycles beat%0d got=%0d exp=%0d", i, r_cycles[i], e_cycles[i]); end
        end
        checks++; if (r_rdata[3] !== e_rdata[3]) begin errors++; $display("FAIL misalign_mem_unchanged got=%h exp=%h", r_rdata[3], e_rdata[3]); end
    endtask

    task automatic test_back_to_back();
        for (int rep = 0; rep < 3; rep++) begin
            logic [31:0] a;
            a = BASE + 32'h40 + 32'(rep * 4);
            nb = 0;
            add_beat(a, 1'b1, 3'd2, 2'b10, 3'd0, $urandom);
            add_beat(a, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
            add_beat(a + 32'(rep), 1'b1, 3'd0, 2'b10, 3'd0, $urandom);
            add_beat(a, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
            model_expect(); run_beats();
            checks++; if (r_rdata[1] !== e_rdata[1]) begin errors++; $display("FAIL b2b_word got=%h exp=%h", r_rdata[1], e_rdata[1]); end
            checks++; if (r_rdata[3] !== e_rdata[3]) begin errors++; $display("FAIL b2b_byte got=%h exp=%h", r_rdata[3], e_rdata[3]); end
        end
    endtask

    task automatic test_burst_check();
        logic [31:0] wrap_ok [4];
        wrap_ok = '{32'h08, 32'h0C, 32'h00, 32'h04};
        nb = 0;
        for (int i = 0; i < 4; i++)
            add_beat(BASE + wrap_ok[i], 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'd2, 32'h0);
        model_expect(); run_beats();
        for (int i = 0; i < nb; i++) begin
            checks++; if (r_resp[i] !== 1'b0) begin errors++; $display("FAIL wrap4_ok_resp beat%0d got=%b exp=0", i, r_resp[i]); end
            checks++; if (r_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL wrap4_ok_rdata beat%0d got=%h exp=%h", i, r_rdata[i], e_rdata[i]); end
        end
        nb = 0;
        add_beat(BASE + 32'h08, 1'b0, 3'd2, 2'b10, 3'd2, 32'h0);
        add_beat(BASE + 32'h0C, 1'b0, 3'd2, 2'b11, 3'd2, 32'h0);
        add_beat(BASE + 32'h10, 1'b0, 3'd2, 2'b11, 3'd2, 32'h0);
        model_expect(); run_beats();
        for (int i = 0; i < nb; i++) begin
            checks++; if (r_resp[i] !== e_err[i]) begin errors++; $display("FAIL wrap4_bad_resp beat%0d got=%b exp=%b", i, r_resp[i], e_err[i]); end
            checks++; if (r_cycles[i] !== e_cycles[i]) begin errors++; $display("FAIL wrap4_bad_cycles beat%0d got=%0d exp=%0d", i, r_cycles[i], e_cycles[i]); end
        end
        nb = 0;
        add_beat(BASE + 32'h20, 1'b0, 3'd2, 2'b11, 3'd1, 32'h0);
        model_expect(); run_beats();
        checks++; if (r_resp[0] !== e_err[0]) begin errors++; $display("FAIL lone_seq_resp got=%b exp=%b", r_resp[0], e_err[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int mode;
            mode = $urandom_range(0, 3);
            nb = 0;
            if (mode < 3) begin
                logic [2:0]  s;
                logic [31:0] off;
                s   = 3'($urandom_range(0, 3));
                off = 32'($urandom_range(0, MEMB - 1));
                if ($urandom_range(0, 3) != 0) off = off & ~((32'd1 << s) - 1);
                if ($urandom_range(0, 9) == 0) off = off + 32'(MEMB);
                add_beat(BASE + off, 1'($urandom_range(0, 1)), s, 2'b10, 3'd0, $urandom);
            end else begin
                logic [31:0] off;
                logic        wr;
                off = 32'($urandom_range(0, MEMB / 4 - 4)) * 4;
                wr  = 1'($urandom_range(0, 1));
                for (int i = 0; i < 4; i++)
                    add_beat(BASE + off + 32'(i*4), wr, 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'd3, $urandom);
            end
            model_expect(); run_beats();
            for (int i = 0; i < nb; i++) begin
                checks++; if (r_cycles[i] !== e_cycles[i]) begin errors++; $display("FAIL rand_cycles it%0d beat%0d got=%0d exp=%0d", it, i, r_cycles[i], e_cycles[i]); end
                checks++; if (r_resp[i] !== e_err[i]) begin errors++; $display("FAIL rand_resp it%0d beat%0d got=%b exp=%b", it, i, r_resp[i], e_err[i]); end
                if (!b_wr[i] && !e_err[i]) begin
                    checks++; if (r_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL rand_rdata it%0d beat%0d got=%h exp=%h", it, i, r_rdata[i], e_rdata[i]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        // write issued outside the model: reset in its DATA cycle must drop it
        hsel = 1'b1; haddr = BASE + 32'h20; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hburst = 3'd0;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = ~{mm[35], mm[34], mm[33], mm[32]};
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL midrst_data_ready got=%b exp=1", hreadyout); end
        hreset = 1'b1;
        @(posedge hclk); #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL midrst_resp got=%b exp=0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", hrdata); end
        hreset = 1'b0;
        @(posedge hclk); #1;
        nb = 0;
        add_beat(BASE + 32'h20, 1'b0, 3'd2, 2'b10, 3'd0, 32'h0);
        model_expect(); run_beats();
        checks++; if (r_rdata[0] !== e_rdata[0]) begin errors++; $display("FAIL midrst_no_write got=%h exp=%h", r_rdata[0], e_rdata[0]); end
    endtask

    initial begin
        hreset = 1'b1; hwdata = '0; drive_idle();
        test_reset();
        init_memory();
        test_single_write_read();
        test_byte_write();
        test_incr4_read();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_burst_check();
        test_random();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
